data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: accepts load/store requests
//  (read/write strobes, byte address, store data) and returns load data after a fixed
//  number of wait states. Handshakes let the datapath stall. Backs a word-organised RAM
//  with byte/half/word lane handling.
// PARAMETERS
//  ADDR_W       8   byte-address width; RAM depth = 2**(ADDR_W-2) words
//  WAIT_CYCLES  1   wait states between acceptance and response (0..15)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       reset: synchronous, active-high
//  req_valid  in   1       request present this cycle
//  req_ready  out  1       responder can accept (high only in IDLE)
//  mem_read   in   1       load request
//  mem_write  in   1       store request
//  addr       in   ADDR_W  byte address
//  size       in   2       00 byte, 01 half, 10 word, 11 reserved
//  wdata      in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1       one-cycle response pulse
//  rdata      out  32      load data, zero-extended, right-aligned; 0 for stores/errors
//  rsp_err    out  1       qualified by rsp_valid; request rejected, RAM untouched
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0. RAM contents kept.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Accept on req_valid&req_ready; latch addr/size/
//    wdata/op. With WAIT_CYCLES=0, IDLE -> RESP directly.
//  - WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on accept; decrements; RESP at 0.
//  - RESP: rsp_valid=1 for exactly one cycle; req_ready=0. Response cycle = accept
//    cycle + WAIT_CYCLES + 1. Next accept is the cycle after RESP.
//  - Store commits at the RESP-entry edge. Word index = addr[ADDR_W-1:2]. Byte lane
//    = addr[1:0]; half lane = addr[1]. Strobe gates write of selected lanes only.
//  - Load samples RAM at the RESP-entry edge (sees stores of earlier transactions).
//  - mem_read&mem_write both high, neither high, or size=11: rsp_err=1, no write.
//  - req_valid while not ready: ignored; requester must hold until accepted.
//  - Reset mid-transaction: FSM to IDLE, no response. An uncommitted store is dropped.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 ->
//   rsp_err=1, rdata=0, no write.
//  Not defined: offending low address bits forced to 0 (access aligned down), never
//   an error for misalignment.
// STRUCTURE
//  dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum
//   (ST_IDLE/ST_WAIT/ST_RESP), WAIT counter width.
//  Sub-module dmem_lane_align (combinational): from size/addr[1:0]/wdata produces
//   4-bit strobe, lane-shifted write word, and extracts/zero-extends read data.
//  Top: FSM, counter, request latches, RAM array, error decode.
// TESTING
//  1 WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid
//    2 cycles after each accept; rdata=0xDEADBEEF, rsp_err=0.
//  2 Store byte 0xAA @0x13 over word 0x11223344 -> load word @0x10 = 0xAA223344;
//    load byte @0x13 = 0x000000AA; load half @0x12 = 0x0000AA22.
//  3 mem_read=mem_write=1 @0x20 (wdata=0x55) -> rsp_err=1, rdata=0; later load @0x20
//    returns prior contents unchanged.
//  4 Word store @0x21 with 0x12345678: macro on -> rsp_err=1, RAM unchanged; macro off
//    -> word 0x20 = 0x12345678, rsp_err=0.
//  5 Assert rst the cycle after a store accept (WAIT_CYCLES=3) -> no rsp_valid,
//    req_ready=1 next cycle, location still holds old value.
//  6 WAIT_CYCLES=0, back-to-back requests held valid -> accept every 2nd cycle,
//    req_ready low exactly during RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, wait-counter width.
package dmem_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: write strobes, lane-replicated store data and
// right-aligned, zero-extended load data for a word-organised RAM.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;

  assign rshift = rword_i >> {offset_i, 3'b000};

  always_comb begin
    strobe_o = 4'b0000;
    wword_o  = '0;
    rdata_o  = '0;
    case (size_i)
      SZ_BYTE: begin
        strobe_o = 4'b0001 << offset_i;
        wword_o  = {4{wdata_i[7:0]}};
        rdata_o  = {24'b0, rshift[7:0]};
      end
      SZ_HALF: begin
        strobe_o = offset_i[1] ? 4'b1100 : 4'b0011;
        wword_o  = {2{wdata_i[15:0]}};
        rdata_o  = {16'b0, rshift[15:0]};
      end
      SZ_WORD: begin
        strobe_o = 4'b1111;
        wword_o  = wdata_i;
        rdata_o  = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, pulses a response.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning down.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem [DEPTH];

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic              rd_q, wr_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size;
  logic [31:0]       cur_wdata;
  logic              cur_rd, cur_wr;
  logic [1:0]        offset;
  logic              misalign, err, enter_resp, mem_we;
  logic [3:0]        strobe;
  logic [31:0]       wword, ext_rdata;
  logic [ADDR_W-3:0] word_idx;

  // With zero wait states the response is entered on the accept edge, so the
  // live request must be used instead of the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr  = addr;
      cur_size  = size;
      cur_wdata = wdata;
      cur_rd    = mem_read;
      cur_wr    = mem_write;
    end else begin
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_wdata = wdata_q;
      cur_rd    = rd_q;
      cur_wr    = wr_q;
    end
  end

  always_comb begin
    case (cur_size)
      SZ_HALF: offset = {cur_addr[1], 1'b0};
      SZ_WORD: offset = 2'b00;
      default: offset = cur_addr[1:0];
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                    ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err        = (cur_rd == cur_wr) || (cur_size == 2'b11) || misalign;
  assign enter_resp = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
  assign mem_we     = enter_resp && !rst && cur_wr && !err;
  assign word_idx   = cur_addr[ADDR_W-1:2];
  assign req_ready  = (state_q == ST_IDLE);

  dmem_lane_align u_lane_align (
    .size_i   (cur_size),
    .offset_i (offset),
    .wdata_i  (cur_wdata),
    .rword_i  (mem[word_idx]),
    .strobe_o (strobe),
    .wword_o  (wword),
    .rdata_o  (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp && err;
      rdata     <= (enter_resp && cur_rd && !err) ? ext_rdata : '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= addr;
            size_q  <= size;
            wdata_q <= wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (1, 0 and 3 wait states) sharing request fields.
module tb_data_mem_responder;

  logic             clk = 1'b0;
  logic [2:0]       rst_v = 3'b111;
  logic [2:0]       req_valid_v = 3'b000;
  logic [2:0]       ready_v, rsp_valid_v, err_v;
  logic [2:0][31:0] rdata_v;
  logic             mem_read = 1'b0, mem_write = 1'b0;
  logic [7:0]       addr = '0;
  logic [1:0]       size = 2'b00;
  logic [31:0]      wdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(ready_v[0]),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .size(size), .wdata(wdata),
    .rsp_valid(rsp_valid_v[0]), .rdata(rdata_v[0]), .rsp_err(err_v[0])
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(ready_v[1]),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .size(size), .wdata(wdata),
    .rsp_valid(rsp_valid_v[1]), .rdata(rdata_v[1]), .rsp_err(err_v[1])
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst_v[2]), .req_valid(req_valid_v[2]), .req_ready(ready_v[2]),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .size(size), .wdata(wdata),
    .rsp_valid(rsp_valid_v[2]), .rdata(rdata_v[2]), .rsp_err(err_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance inst; returns response data, error and latency in cycles.
  task automatic xact(input int inst, input logic rd, input logic wr, input logic [7:0] a,
                      input logic [1:0] sz, input logic [31:0] wd,
                      output logic [31:0] rdo, output logic erro, output int lat);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; size = sz; wdata = wd;
    req_valid_v[inst] = 1'b1;
    chk("ready_before_accept", 32'(ready_v[inst]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_v[inst] = 1'b0;
    lat = 1;
    while (!rsp_valid_v[inst] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdo  = rdata_v[inst];
    erro = err_v[inst];
    @(negedge clk);
    chk("rsp_pulse_ends", 32'(rsp_valid_v[inst]), 32'd0);
    chk("ready_after_resp", 32'(ready_v[inst]), 32'd1);
  endtask

  logic [31:0] rd_data;
  logic        rd_err;
  int          lat;
  int          pulses;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready_v[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    chk("reset_rdata", rdata_v[0], 32'd0);
    chk("reset_err", 32'(err_v[0]), 32'd0);
    rst_v = 3'b000;

    // Word store then load, one wait state.
    xact(0, 1'b0, 1'b1, 8'h10, 2'b10, 32'hDEADBEEF, rd_data, rd_err, lat);
    chk("st_word_lat", lat, 2);
    chk("st_word_err", 32'(rd_err), 32'd0);
    chk("st_word_rdata", rd_data, 32'd0);
    xact(0, 1'b1, 1'b0, 8'h10, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("ld_word_lat", lat, 2);
    chk("ld_word_rdata", rd_data, 32'hDEADBEEF);
    chk("ld_word_err", 32'(rd_err), 32'd0);

    // Byte store into an existing word, then word/byte/half reads.
    xact(0, 1'b0, 1'b1, 8'h10, 2'b10, 32'h11223344, rd_data, rd_err, lat);
    xact(0, 1'b0, 1'b1, 8'h13, 2'b00, 32'h000000AA, rd_data, rd_err, lat);
    chk("st_byte_err", 32'(rd_err), 32'd0);
    xact(0, 1'b1, 1'b0, 8'h10, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("ld_merged_word", rd_data, 32'hAA223344);
    xact(0, 1'b1, 1'b0, 8'h13, 2'b00, 32'h0, rd_data, rd_err, lat);
    chk("ld_byte3", rd_data, 32'h000000AA);
    xact(0, 1'b1, 1'b0, 8'h12, 2'b01, 32'h0, rd_data, rd_err, lat);
    chk("ld_half_hi", rd_data, 32'h0000AA22);
    xact(0, 1'b1, 1'b0, 8'h10, 2'b00, 32'h0, rd_data, rd_err, lat);
    chk("ld_byte0", rd_data, 32'h00000044);

    // Illegal requests leave RAM untouched.
    xact(0, 1'b0, 1'b1, 8'h20, 2'b10, 32'hCAFEF00D, rd_data, rd_err, lat);
    xact(0, 1'b1, 1'b1, 8'h20, 2'b00, 32'h00000055, rd_data, rd_err, lat);
    chk("both_ops_err", 32'(rd_err), 32'd1);
    chk("both_ops_rdata", rd_data, 32'd0);
    xact(0, 1'b0, 1'b0, 8'h20, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("no_op_err", 32'(rd_err), 32'd1);
    xact(0, 1'b0, 1'b1, 8'h20, 2'b11, 32'h77777777, rd_data, rd_err, lat);
    chk("rsvd_size_err", 32'(rd_err), 32'd1);
    xact(0, 1'b1, 1'b0, 8'h20, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("after_err_word", rd_data, 32'hCAFEF00D);
    chk("after_err_err", 32'(rd_err), 32'd0);

    // Misaligned word store.
    xact(0, 1'b0, 1'b1, 8'h21, 2'b10, 32'h12345678, rd_data, rd_err, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("misalign_err", 32'(rd_err), 32'd1);
    xact(0, 1'b1, 1'b0, 8'h20, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("misalign_ram", rd_data, 32'hCAFEF00D);
`else
    chk("misalign_err", 32'(rd_err), 32'd0);
    xact(0, 1'b1, 1'b0, 8'h20, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("misalign_ram", rd_data, 32'h12345678);
`endif

    // Reset one cycle after a store accept, three wait states.
    xact(2, 1'b0, 1'b1, 8'h30, 2'b10, 32'h0BADF00D, rd_data, rd_err, lat);
    chk("w3_lat", lat, 4);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; addr = 8'h30; size = 2'b10; wdata = 32'h99999999;
    req_valid_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[2] = 1'b0;
    rst_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_v[2] = 1'b0;
    chk("rst_ready", 32'(ready_v[2]), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_v[2]) pulses++;
      @(negedge clk);
    end
    chk("rst_no_rsp", pulses, 0);
    xact(2, 1'b1, 1'b0, 8'h30, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("rst_store_dropped", rd_data, 32'h0BADF00D);

    // Zero wait states, request held valid: accept every other cycle.
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; addr = 8'h08; size = 2'b10; wdata = 32'h5A5A5A5A;
    req_valid_v[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_ready_%0d", i), 32'(ready_v[1]), 32'((i % 2) == 0));
      chk($sformatf("b2b_rsp_%0d", i), 32'(rsp_valid_v[1]), 32'((i % 2) == 1));
      @(negedge clk);
    end
    req_valid_v[1] = 1'b0;
    xact(1, 1'b1, 1'b0, 8'h08, 2'b10, 32'h0, rd_data, rd_err, lat);
    chk("w0_lat", lat, 1);
    chk("w0_rdata", rd_data, 32'h5A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
